// File: rtl/addsub_comparator_logop.sv
// Registered ALU execution cluster: adder/subtractor, comparator and logic unit on shared operands.
// Optional macro CMP_SLT_RESULT_EN drives the SLT/SLTU result word onto Comparator_out.
module addsub_comparator_logop (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        dat_ready,
  input  logic [31:0] ALU_dat1,
  input  logic [31:0] ALU_dat2,
  input  logic [4:0]  Instruction_to_ALU,
  output logic [31:0] AddSub_out,
  output logic        AddSub_overflow,
  output logic        AddSub_zero,
  output logic [31:0] Comparator_out,
  output logic        Comparator_con_met,
  output logic [31:0] LogOp_out
);

  typedef struct packed {
    logic [31:0] as_res;
    logic        as_ovf;
    logic        as_zero;
    logic [31:0] cmp_res;
    logic        cmp_con;
    logic [31:0] lo_res;
  } res_t;

  res_t        nxt, q;
  logic [31:0] sum, diff;
  logic        eq, slt, ult;

  always_comb begin
    sum  = ALU_dat1 + ALU_dat2;
    diff = ALU_dat1 - ALU_dat2;
    eq   = (ALU_dat1 == ALU_dat2);
    slt  = ($signed(ALU_dat1) < $signed(ALU_dat2));
    ult  = (ALU_dat1 < ALU_dat2);
    nxt  = '0;

    case (Instruction_to_ALU)
      5'd6: begin
        nxt.as_res  = sum;
        nxt.as_ovf  = (ALU_dat1[31] == ALU_dat2[31]) && (sum[31] != ALU_dat1[31]);
        nxt.as_zero = (sum == 32'd0);
      end
      5'd7: begin
        nxt.as_res  = diff;
        nxt.as_ovf  = (ALU_dat1[31] != ALU_dat2[31]) && (diff[31] != ALU_dat1[31]);
        nxt.as_zero = (diff == 32'd0);
      end
      default: ;
    endcase

    case (Instruction_to_ALU)
      5'd0:        nxt.cmp_con = eq;
      5'd1:        nxt.cmp_con = !eq;
      5'd2, 5'd9:  nxt.cmp_con = slt;
      5'd3:        nxt.cmp_con = !slt;
      5'd4, 5'd10: nxt.cmp_con = ult;
      5'd5:        nxt.cmp_con = !ult;
      default: ;
    endcase
`ifdef CMP_SLT_RESULT_EN
    if (Instruction_to_ALU == 5'd9 || Instruction_to_ALU == 5'd10)
      nxt.cmp_res = {31'b0, nxt.cmp_con};
`endif

    case (Instruction_to_ALU)
      5'd11:   nxt.lo_res = ALU_dat1 ^ ALU_dat2;
      5'd14:   nxt.lo_res = ALU_dat1 | ALU_dat2;
      5'd15:   nxt.lo_res = ALU_dat1 & ALU_dat2;
      default: ;
    endcase
  end

  // Single result register; dat_ready low holds every unit's last result.
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset)         q <= '0;
    else if (dat_ready) q <= nxt;
  end

  assign AddSub_out         = q.as_res;
  assign AddSub_overflow    = q.as_ovf;
  assign AddSub_zero        = q.as_zero;
  assign Comparator_out     = q.cmp_res;
  assign Comparator_con_met = q.cmp_con;
  assign LogOp_out          = q.lo_res;

endmodule

// File: tb/tb_addsub_comparator_logop.sv
// Randomized bench for addsub_comparator_logop against an arithmetic reference model.
module tb_addsub_comparator_logop;
  logic        soc_clk = 1'b0;
  logic        reset = 1'b0;
  logic        dat_ready = 1'b0;
  logic [31:0] ALU_dat1 = '0, ALU_dat2 = '0;
  logic [4:0]  Instruction_to_ALU = '0;
  logic [31:0] AddSub_out, Comparator_out, LogOp_out;
  logic        AddSub_overflow, AddSub_zero, Comparator_con_met;

  int nvec = 0;
  int nerr = 0;
  bit started = 1'b0;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  typedef logic [98:0] vec_t;

  addsub_comparator_logop dut (
    .soc_clk(soc_clk), .reset(reset), .dat_ready(dat_ready),
    .ALU_dat1(ALU_dat1), .ALU_dat2(ALU_dat2), .Instruction_to_ALU(Instruction_to_ALU),
    .AddSub_out(AddSub_out), .AddSub_overflow(AddSub_overflow), .AddSub_zero(AddSub_zero),
    .Comparator_out(Comparator_out), .Comparator_con_met(Comparator_con_met),
    .LogOp_out(LogOp_out)
  );

  always #5 soc_clk = ~soc_clk;

  function automatic vec_t mk(logic [31:0] as_r, logic ovf, logic z,
                              logic [31:0] cmp, logic con, logic [31:0] lo);
    return {as_r, ovf, z, cmp, con, lo};
  endfunction

  // Reference: overflow from exact 64-bit signed arithmetic, compares on widened integers.
  function automatic vec_t ref_model(logic [31:0] a, logic [31:0] b, logic [4:0] op);
    longint sa, sb, ua, ub, ex;
    logic [31:0] as_r, cmp, lo;
    logic ovf, z, con;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    as_r = '0; ovf = 0; z = 0; cmp = '0; con = 0; lo = '0;
    if (op == 5'd6 || op == 5'd7) begin
      ex   = (op == 5'd6) ? sa + sb : sa - sb;
      as_r = ex[31:0];
      ovf  = (ex > MAXS) || (ex < MINS);
      z    = (as_r == 32'd0);
    end
    case (op)
      5'd0: con = (ua == ub);
      5'd1: con = (ua != ub);
      5'd2, 5'd9: con = (sa < sb);
      5'd3: con = (sa >= sb);
      5'd4, 5'd10: con = (ua < ub);
      5'd5: con = (ua >= ub);
      default: con = 0;
    endcase
`ifdef CMP_SLT_RESULT_EN
    if (op == 5'd9 || op == 5'd10) cmp = con ? 32'd1 : 32'd0;
`endif
    case (op)
      5'd11: lo = a ^ b;
      5'd14: lo = a | b;
      5'd15: lo = a & b;
      default: lo = '0;
    endcase
    return mk(as_r, ovf, z, cmp, con, lo);
  endfunction

  vec_t expm = '0;
  wire vec_t dut_vec = {AddSub_out, AddSub_overflow, AddSub_zero,
                        Comparator_out, Comparator_con_met, LogOp_out};

  always @(posedge soc_clk or negedge reset)
    if (!reset)         expm <= '0;
    else if (dat_ready) expm <= ref_model(ALU_dat1, ALU_dat2, Instruction_to_ALU);

  task automatic chk(string name, vec_t act, vec_t exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s act=%h exp=%h (op=%0d a=%h b=%h)", name, act, exp,
               Instruction_to_ALU, ALU_dat1, ALU_dat2);
    end
  endtask

  always @(negedge soc_clk)
    if (started) chk("model", dut_vec, expm);

  task automatic apply(logic [31:0] a, logic [31:0] b, logic [4:0] op);
    @(posedge soc_clk); #1;
    dat_ready = 1'b1; ALU_dat1 = a; ALU_dat2 = b; Instruction_to_ALU = op;
    @(posedge soc_clk); #2;
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = 32'h7FFFFFFF;
      3: v = 32'h80000000;
      4: v = 32'hFFFFFFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  logic [4:0] codes [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                             5'd9, 5'd10, 5'd11, 5'd14, 5'd15};

  initial begin
    #1 chk("reset_init", dut_vec, '0);
    started = 1'b1;
    @(negedge soc_clk); reset = 1'b1;

    apply(32'h7FFFFFFF, 32'h1, 5'd6);
    chk("add_ovf", dut_vec, mk(32'h80000000, 1, 0, 0, 0, 0));
    apply(32'd5, 32'd5, 5'd7);
    chk("sub_zero", dut_vec, mk(32'h0, 0, 1, 0, 0, 0));
    apply(32'h80000000, 32'h1, 5'd7);
    chk("sub_ovf", dut_vec, mk(32'h7FFFFFFF, 1, 0, 0, 0, 0));
    apply(32'hFFFFFFFF, 32'h1, 5'd2);
    chk("blt", dut_vec, mk(0, 0, 0, 0, 1, 0));
    apply(32'hFFFFFFFF, 32'h1, 5'd4);
    chk("bltu", dut_vec, '0);
    apply(32'hFFFFFFFF, 32'h1, 5'd10);
    chk("sltu", dut_vec, '0);
    apply(32'hFFFFFFFF, 32'h1, 5'd9);
`ifdef CMP_SLT_RESULT_EN
    chk("slt", dut_vec, mk(0, 0, 0, 32'd1, 1, 0));
`else
    chk("slt", dut_vec, mk(0, 0, 0, 32'd0, 1, 0));
`endif
    apply(32'hF0F0F0F0, 32'hFF00FF00, 5'd11);
    chk("xor", dut_vec, mk(0, 0, 0, 0, 0, 32'h0FF00FF0));
    apply(32'hF0F0F0F0, 32'hFF00FF00, 5'd14);
    chk("or", dut_vec, mk(0, 0, 0, 0, 0, 32'hFFF0FFF0));
    apply(32'hF0F0F0F0, 32'hFF00FF00, 5'd15);
    chk("and", dut_vec, mk(0, 0, 0, 0, 0, 32'hF000F000));

    @(posedge soc_clk); #1;
    dat_ready = 1'b0; ALU_dat1 = 32'h12345678; ALU_dat2 = 32'h9ABCDEF0; Instruction_to_ALU = 5'd6;
    repeat (2) @(posedge soc_clk); #2;
    chk("hold", dut_vec, mk(0, 0, 0, 0, 0, 32'hF000F000));

    apply(32'hDEADBEEF, 32'h1, 5'd16);
    chk("noop16", dut_vec, '0);

    apply(32'h7FFFFFFF, 32'h1, 5'd6);
    #1 reset = 1'b0;
    #1 chk("async_reset", dut_vec, '0);
    #1 reset = 1'b1;

    for (int i = 0; i < 500; i++) begin
      @(posedge soc_clk); #1;
      dat_ready = ($urandom_range(0, 3) != 0);
      ALU_dat1 = rnd_op();
      ALU_dat2 = ($urandom_range(0, 7) == 0) ? ALU_dat1 : rnd_op();
      Instruction_to_ALU = ($urandom_range(0, 3) != 0) ? codes[$urandom_range(0, 12)]
                                                      : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 40) == 0) begin
        #1 reset = 1'b0;
        #2 reset = 1'b1;
      end
    end

    @(posedge soc_clk); #1;
    @(negedge soc_clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
